// File: rtl/vip_stream_pkg.sv
// Shared constants for the VIP streaming output stage: packet type codes
// carried in the low bits of symbol 0 of a sop beat, and the sync modes.
package vip_stream_pkg;

  localparam int TYPE_BITS = 4;

  localparam logic [TYPE_BITS-1:0] IMAGE_TYPE   = 4'h0;
  localparam logic [TYPE_BITS-1:0] CONTROL_TYPE = 4'hF;

  // Which packet eops open the window in which the enable request is sampled.
  localparam int SYNC_IMAGE_EOP = 0;
  localparam int SYNC_ANY_EOP   = 1;

  // True when a sop beat's type field announces an image packet.
  function automatic logic is_image_type(input logic [TYPE_BITS-1:0] t);
    return (t == IMAGE_TYPE);
  endfunction

endpackage

// File: rtl/vip_stream_fifo.sv
// Small synchronous FIFO holding {sop, eop, data} beats. The head entry is
// presented combinationally from storage (latency 0), while full, empty and
// level are registered so the consumers see glitch-free flow-control state.
module vip_stream_fifo #(
  parameter int WIDTH   = 12,
  parameter int DEPTH   = 4,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic [WIDTH-1:0]   i_din,
  input  logic               i_pop,
  output logic [WIDTH-1:0]   o_head,
  output logic               o_full,
  output logic               o_empty,
  output logic [LEVEL_W-1:0] o_level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LEVEL_W-1:0] r_level;
  logic               r_full;
  logic               r_empty;

  logic               w_do_push;
  logic               w_do_pop;
  logic [LEVEL_W-1:0] w_level_nxt;

  // Never write a full FIFO or read an empty one, even if the caller asks.
  assign w_do_push = i_push & ~r_full;
  assign w_do_pop  = i_pop  & ~r_empty;

  // Next fill level: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_do_push, w_do_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  // Storage and pointers; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Registered occupancy and the full/empty flags derived from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LEVEL_W'(DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;

endmodule

// File: rtl/vip_stream_output_sync.sv
// Avalon-ST video output stage. Beats from the core are buffered in a small
// FIFO and forwarded to dout. The run/stop request on 'enable' is only
// sampled at a packet boundary, so several outputs started or stopped by a
// shared enable change frames in lock-step.
//
// Handshake: both sides use ready latency 0. A beat transfers on a cycle
// where valid and ready are both high at the clock edge; valid never depends
// combinationally on ready, and data/sop/eop are stable while valid is high.
module vip_stream_output_sync
  import vip_stream_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 10,
  parameter int SYMBOLS_PER_BEAT = 1,
  parameter int FIFO_DEPTH       = 4,
  parameter int SYNC_MODE        = 0,
  parameter int COUNT_WIDTH      = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        int_valid,
  output logic                                        int_ready,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] int_data,
  input  logic                                        int_sop,
  input  logic                                        int_eop,
  output logic                                        dout_valid,
  input  logic                                        dout_ready,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
  output logic                                        dout_sop,
  output logic                                        dout_eop,
  input  logic                                        enable,
  output logic                                        synced,
  output logic [COUNT_WIDTH-1:0]                      frame_count,
  output logic [$clog2(FIFO_DEPTH):0]                 fill_level
);

  localparam int   DATA_WIDTH = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam int   ENTRY_W    = DATA_WIDTH + 2;
  localparam int   LEVEL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic SYNC_ANY   = (SYNC_MODE == SYNC_ANY_EOP);

  // Effective run state and the packet tracking behind it.
  logic                   r_en_q;
  logic                   r_at_boundary;
  logic                   r_image_pkt;
  logic [COUNT_WIDTH-1:0] r_frame_count;

  logic [ENTRY_W-1:0]     w_head;
  logic                   w_full;
  logic                   w_empty;
  logic [LEVEL_W-1:0]     w_level;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_head_sop;
  logic                   w_head_eop;
  logic                   w_sop_x;
  logic                   w_eop_x;
  logic                   w_type_img;
  logic                   w_cur_img;
  logic                   w_image_pkt_nxt;
  logic                   w_at_boundary_nxt;

  vip_stream_fifo #(
    .WIDTH   (ENTRY_W),
    .DEPTH   (FIFO_DEPTH),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   ({int_sop, int_eop, int_data}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Both ports are frozen while stopped, so held beats survive a pause.
  assign int_ready  = r_en_q & ~w_full;
  assign dout_valid = r_en_q & ~w_empty;
  assign w_push     = int_valid & int_ready;
  assign w_pop      = dout_valid & dout_ready;

  assign w_head_sop = w_head[DATA_WIDTH+1];
  assign w_head_eop = w_head[DATA_WIDTH];

  // Packet decode on output transfers; cur_img also covers a packet whose
  // sop and eop arrive on the same beat.
  always_comb begin
    w_sop_x           = w_pop & w_head_sop;
    w_eop_x           = w_pop & w_head_eop;
    w_type_img        = is_image_type(w_head[TYPE_BITS-1:0]);
    w_image_pkt_nxt   = (w_sop_x & w_type_img) | (r_image_pkt & ~w_eop_x);
    w_cur_img         = r_image_pkt | (w_sop_x & w_type_img);
    w_at_boundary_nxt = (w_eop_x & (w_cur_img | SYNC_ANY)) |
                        (r_at_boundary & ~w_sop_x);
  end

  // Boundary tracking, enable sampling between packets and image-frame count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_at_boundary <= 1'b1;
      r_image_pkt   <= 1'b0;
      r_en_q        <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_at_boundary <= w_at_boundary_nxt;
      r_image_pkt   <= w_image_pkt_nxt;
      if (w_at_boundary_nxt) r_en_q <= enable;
      if (w_eop_x && w_cur_img) r_frame_count <= r_frame_count + 1'b1;
    end
  end

  assign dout_data   = w_head[DATA_WIDTH-1:0];
  assign dout_sop    = w_head_sop;
  assign dout_eop    = w_head_eop;
  assign synced      = ~r_en_q;
  assign frame_count = r_frame_count;
  assign fill_level  = w_level;

endmodule
